spi_frame_ctrl: RTL and testbench

//  Upstream feeder and downstream collector for spi_master: buffers TX bytes in a FIFO, sequences
//  one start/data_in per byte under a frame-wide cs_n, and captures data_out into an RX FIFO.

---
 rtl/spi_frame_pkg.sv | 29 ++
 rtl/spi_sync_fifo.sv | 81 ++++++++
 rtl/spi_frame_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// ---------------------------------------------------------------------------
// spi_frame_pkg
//  Shared types and default parameters for the SPI frame controller slice.
//  Contents:
//   state_t      frame sequencer states
//   DEF_*        default widths/depths/timings used by spi_frame_ctrl
//   cnt_width()  bit width needed to hold a counter value 0..max_val
// ---------------------------------------------------------------------------
package spi_frame_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CS_GAP     = 2;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Always at least one bit so a zero-valued parameter still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// ---------------------------------------------------------------------------
// spi_sync_fifo
//  Single-clock FIFO with first-word-fall-through head (pop_data always shows
//  the oldest entry while empty==0).
//  Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2)
//  Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pointers only)
//   flush            discard all stored entries (a same-cycle push is kept)
//   push, push_data  write an entry; accepted when not full or when popping
//   pop, pop_data    remove the head entry; ignored when empty
//   full, empty      occupancy flags
// ---------------------------------------------------------------------------
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are DEPTH-sized (power of 2), so natural overflow wraps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        count_reg  <= CW'(1);
      end else begin
        count_reg  <= '0;
      end
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// spi_frame_ctrl
//  Feeds spi_master one byte at a time from a TX FIFO and collects its
//  received bytes into an RX FIFO, holding cs_n low across a whole frame
//  (bytes up to and including the one tagged tx_last).
//  Optional feature macro: SPI_FRAME_WDOG_EN -- watchdog on the
//  WAIT_BUSY/WAIT_DONE states; on expiry pulses err, flushes TX, releases
//  cs_n and returns to IDLE. Without it err is constant 0.
//  Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   tx_data/tx_last/tx_valid    upstream byte stream, tx_ready = TX not full
//   rx_data/rx_valid/rx_ready   downstream byte stream (RX FIFO head)
//   spi_start/spi_data_in       one-cycle launch and byte to spi_master
//   spi_busy/spi_data_out/
//   spi_valid_data              status and received byte from spi_master
//   cs_n                        slave select, active low
//   frame_done                  1-cycle pulse when a frame's last byte lands
//   err                         1-cycle watchdog timeout pulse
// ---------------------------------------------------------------------------
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CS_GAP     = DEF_CS_GAP,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_data_in,
  input  logic                  spi_busy,
  input  logic [DATA_WIDTH-1:0] spi_data_out,
  input  logic                  spi_valid_data,
  output logic                  cs_n,
  output logic                  frame_done,
  output logic                  err
);

  localparam int TX_W  = DATA_WIDTH + 1;
  localparam int GAP_W = cnt_width(CS_GAP);

  // FIFO plumbing
  logic            tx_push;
  logic            tx_pop;
  logic            tx_flush;
  logic            tx_full;
  logic            tx_empty;
  logic [TX_W-1:0] tx_head;
  logic            rx_push;
  logic            rx_pop;
  logic            rx_full;
  logic            rx_empty;

  // Sequencer state
  state_t                state_reg, state_next;
  logic                  cs_n_reg, cs_n_next;
  logic                  spi_start_reg, spi_start_next;
  logic [DATA_WIDTH-1:0] spi_data_in_reg, spi_data_in_next;
  logic                  last_reg, last_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  err_reg, err_next;
  logic [GAP_W-1:0]      gap_reg, gap_next;

`ifdef SPI_FRAME_WDOG_EN
  localparam int WDOG_W = cnt_width(TIMEOUT);
  logic [WDOG_W-1:0]     wdog_reg, wdog_next;
`endif

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;

  assign spi_start   = spi_start_reg;
  assign spi_data_in = spi_data_in_reg;
  assign cs_n        = cs_n_reg;
  assign frame_done  = frame_done_reg;
  assign err         = err_reg;

  // TX entries carry the tx_last tag in the top bit.
  spi_sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (tx_flush),
    .push      (tx_push),
    .push_data ({tx_last, tx_data}),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  spi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (rx_push),
    .push_data (spi_data_out),
    .pop       (rx_pop),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_comb begin
    state_next       = state_reg;
    cs_n_next        = cs_n_reg;
    spi_start_next   = 1'b0;
    spi_data_in_next = spi_data_in_reg;
    last_next        = last_reg;
    frame_done_next  = 1'b0;
    err_next         = 1'b0;
    gap_next         = (gap_reg != '0) ? gap_reg - 1'b1 : gap_reg;
    tx_pop           = 1'b0;
    tx_flush         = 1'b0;
    rx_push          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!tx_empty && (gap_reg == '0)) begin
          state_next = CS_SETUP;
          cs_n_next  = 1'b0;
        end
      end

      CS_SETUP: begin
        state_next = LAUNCH;
      end

      // Holding here covers both a mid-frame TX underrun and RX back-pressure:
      // a byte is only launched once its reply is guaranteed a slot in RX.
      LAUNCH: begin
        if (!tx_empty && !rx_full && !spi_busy) begin
          tx_pop           = 1'b1;
          spi_data_in_next = tx_head[DATA_WIDTH-1:0];
          last_next        = tx_head[DATA_WIDTH];
          spi_start_next   = 1'b1;
          state_next       = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (spi_busy) begin
          state_next = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (spi_valid_data) begin
          rx_push = 1'b1;
          if (last_reg) begin
            state_next      = IDLE;
            cs_n_next       = 1'b1;
            frame_done_next = 1'b1;
            gap_next        = GAP_W'(CS_GAP);
          end else begin
            state_next = LAUNCH;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cs_n_next  = 1'b1;
      end
    endcase

`ifdef SPI_FRAME_WDOG_EN
    // A byte completing on the expiry cycle wins over the timeout.
    if (((state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE)) &&
        (state_next == state_reg) &&
        (wdog_reg == WDOG_W'(TIMEOUT - 1))) begin
      state_next = IDLE;
      cs_n_next  = 1'b1;
      err_next   = 1'b1;
      tx_flush   = 1'b1;
      gap_next   = GAP_W'(CS_GAP);
    end

    if (((state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE)) &&
        (state_next == state_reg)) begin
      wdog_next = wdog_reg + 1'b1;
    end else begin
      wdog_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cs_n_reg        <= 1'b1;
      spi_start_reg   <= 1'b0;
      spi_data_in_reg <= '0;
      last_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      err_reg         <= 1'b0;
      gap_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      cs_n_reg        <= cs_n_next;
      spi_start_reg   <= spi_start_next;
      spi_data_in_reg <= spi_data_in_next;
      last_reg        <= last_next;
      frame_done_reg  <= frame_done_next;
      err_reg         <= err_next;
      gap_reg         <= gap_next;
    end
  end

`ifdef SPI_FRAME_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_next;
    end
  end
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_ctrl
//  Table-driven frames plus hand-written corner sequences for spi_frame_ctrl.
//  A behavioural spi_master answers each start with busy then a valid_data
//  pulse carrying (spi_data_in ^ KEY). Expected TX and RX bytes are queued
//  when stimulus is driven and popped when the DUT launches / delivers.
// ---------------------------------------------------------------------------
module tb_spi_frame_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 64;
  localparam logic [7:0] KEY = 8'h99;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_last;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          spi_start;
  logic [DW-1:0] spi_data_in;
  logic          spi_busy;
  logic [DW-1:0] spi_data_out;
  logic          spi_valid_data;
  logic          cs_n;
  logic          frame_done;
  logic          err;

  always #5 clk = ~clk;

  spi_frame_ctrl #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CS_GAP     (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .tx_last        (tx_last),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .spi_start      (spi_start),
    .spi_data_in    (spi_data_in),
    .spi_busy       (spi_busy),
    .spi_data_out   (spi_data_out),
    .spi_valid_data (spi_valid_data),
    .cs_n           (cs_n),
    .frame_done     (frame_done),
    .err            (err)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  logic model_en   = 1'b1;
  logic model_hold = 1'b0;
  logic [7:0] model_cur;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Drive one byte; returns at the negedge after the handshake completes.
  task automatic push_byte(input logic [7:0] d, input logic l, input logic [7:0] e);
    int n = 0;
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(e);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("tx_push_handshake", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    $display("tx txn data=%h last=%0b", d, l);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_arrival", done_cnt >= target, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // Behavioural spi_master
  initial begin
    spi_busy       = 1'b0;
    spi_valid_data = 1'b0;
    spi_data_out   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        start_cnt++;
        model_cur = spi_data_in;
        check("start_expected", exp_tx_q.size() > 0, 1'b1);
        if (exp_tx_q.size() > 0) check("spi_data_in", model_cur, exp_tx_q.pop_front());
        $display("spi txn start data_in=%h", model_cur);
        if (model_en) begin
          while (model_hold) @(negedge clk);
          spi_busy = 1'b1;
          repeat (3) @(negedge clk);
          if (rst_n) check("data_in_stable", spi_data_in, model_cur);
          spi_busy       = 1'b0;
          spi_valid_data = 1'b1;
          spi_data_out   = model_cur ^ KEY;
          @(negedge clk);
          spi_valid_data = 1'b0;
        end
      end
    end
  end

  // RX consumer / scoreboard compare
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rx_valid && rx_ready) begin
        check("rx_expected", exp_rx_q.size() > 0, 1'b1);
        if (exp_rx_q.size() > 0) check("rx_data", rx_data, exp_rx_q.pop_front());
        $display("rx txn data=%h", rx_data);
      end
    end
  end

  // cs_n / frame_done protocol monitor
  logic prev_cs_n  = 1'b1;
  logic seen_frame = 1'b0;
  int   high_cnt   = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs_n  = 1'b1;
        seen_frame = 1'b0;
        high_cnt   = 0;
      end else begin
        if (frame_done) done_cnt++;
        if (err) err_cnt++;
        if (spi_start) check("cs_low_at_start", cs_n, 1'b0);
        if (!prev_cs_n && cs_n) begin
          check("cs_rise_with_done", frame_done | err, 1'b1);
          seen_frame = 1'b1;
          high_cnt   = 0;
        end
        if (prev_cs_n && !cs_n && seen_frame) check("cs_gap", high_cnt >= GAP, 1'b1);
        if (cs_n) high_cnt++;
        prev_cs_n = cs_n;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int bs, bd, n;
    tbl[0] = '{data: 8'hA5, last: 1'b1, exp_rx: 8'h3C};
    tbl[1] = '{data: 8'h01, last: 1'b0, exp_rx: 8'h98};
    tbl[2] = '{data: 8'h02, last: 1'b0, exp_rx: 8'h9B};
    tbl[3] = '{data: 8'h03, last: 1'b1, exp_rx: 8'h9A};
    tbl[4] = '{data: 8'h10, last: 1'b0, exp_rx: 8'h89};
    tbl[5] = '{data: 8'h11, last: 1'b1, exp_rx: 8'h88};
    tbl[6] = '{data: 8'h20, last: 1'b1, exp_rx: 8'hB9};

    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    rx_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_spi_start", spi_start, 1'b0);
    check("rst_spi_data_in", spi_data_in, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, then a 3-byte frame, then back-to-back frames (table order)
    bs = start_cnt; bd = done_cnt;
    push_byte(tbl[0].data, tbl[0].last, tbl[0].exp_rx);
    wait_done(bd + 1);
    check("single_starts", start_cnt - bs, 1);
    check("single_done", done_cnt - bd, 1);

    bs = start_cnt; bd = done_cnt;
    for (int i = 1; i <= 3; i++) push_byte(tbl[i].data, tbl[i].last, tbl[i].exp_rx);
    wait_done(bd + 1);
    check("frame3_starts", start_cnt - bs, 3);
    check("frame3_done", done_cnt - bd, 1);

    bs = start_cnt; bd = done_cnt;
    for (int i = 4; i <= 6; i++) push_byte(tbl[i].data, tbl[i].last, tbl[i].exp_rx);
    wait_done(bd + 2);
    check("b2b_starts", start_cnt - bs, 3);
    check("b2b_done", done_cnt - bd, 2);

    // 9 bytes with spi_master stalled: first byte in flight, 8 fill TX
    model_hold = 1'b1;
    bs = start_cnt; bd = done_cnt;
    for (int i = 0; i < 9; i++) push_byte(8'h40 + 8'(i), (i == 8), (8'h40 + 8'(i)) ^ KEY);
    check("hold_tx_full", tx_ready, 1'b0);
    check("hold_one_start", start_cnt - bs, 1);
    model_hold = 1'b0;
    wait_done(bd + 1);
    check("hold_starts", start_cnt - bs, 9);

    // RX back-pressure: 8 captured, ninth launch held with cs_n low
    rx_ready = 1'b0;
    bs = start_cnt; bd = done_cnt;
    for (int i = 0; i < 9; i++) push_byte(8'hC0 + 8'(i), (i == 8), (8'hC0 + 8'(i)) ^ KEY);
    n = 0;
    while (start_cnt < bs + 8 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("stall_starts", start_cnt - bs, 8);
    check("stall_cs_low", cs_n, 1'b0);
    check("stall_rx_valid", rx_valid, 1'b1);
    check("stall_no_done", done_cnt - bd, 0);
    rx_ready = 1'b1;
    wait_done(bd + 1);
    check("stall_starts_final", start_cnt - bs, 9);

`ifdef SPI_FRAME_WDOG_EN
    // spi_master never answers: watchdog must abort the frame
    model_en = 1'b0;
    bs = start_cnt;
    push_byte(8'h5A, 1'b0, 8'h5A ^ KEY);
    push_byte(8'h5B, 1'b1, 8'h5B ^ KEY);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      #1;
      if (spi_start) break;
      n++;
    end
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      n++;
      if (err) break;
    end
    check("wdog_err_seen", err, 1'b1);
    check("wdog_latency_window", (n >= TMO - 1) && (n <= TMO + 1), 1'b1);
    check("wdog_cs_n", cs_n, 1'b1);
    @(negedge clk);
    #1;
    check("wdog_err_one_cycle", err, 1'b0);
    repeat (20) @(negedge clk);
    check("wdog_tx_flushed_no_restart", start_cnt - bs, 1);
    check("wdog_cs_idle", cs_n, 1'b1);
    check("wdog_rx_empty", rx_valid, 1'b0);
    exp_tx_q.delete();
    exp_rx_q.delete();
    model_en = 1'b1;
`endif

    // Asynchronous reset while spi_start is high
    push_byte(8'h55, 1'b0, 8'h55 ^ KEY);
    push_byte(8'h66, 1'b0, 8'h66 ^ KEY);
    push_byte(8'h77, 1'b1, 8'h77 ^ KEY);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      #1;
      if (spi_start) break;
      n++;
    end
    check("rstmid_start_seen", spi_start, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_cs_n", cs_n, 1'b1);
    check("rstmid_spi_start", spi_start, 1'b0);
    check("rstmid_data_in", spi_data_in, 8'h00);
    check("rstmid_tx_ready", tx_ready, 1'b1);
    check("rstmid_rx_valid", rx_valid, 1'b0);
    repeat (10) @(negedge clk);
    exp_tx_q.delete();
    exp_rx_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    bs = start_cnt; bd = done_cnt;
    push_byte(tbl[0].data, tbl[0].last, tbl[0].exp_rx);
    wait_done(bd + 1);
    check("post_reset_starts", start_cnt - bs, 1);

    repeat (5) @(negedge clk);
    check("tx_queue_drained", exp_tx_q.size(), 0);
    check("rx_queue_drained", exp_rx_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
